// File: rtl/serial_adder_n.sv
// Purpose : bit-serial adder/subtractor, one full-adder cell reused LSB-first over WIDTH cycles.
// Latency : WIDTH cycles from the accepting edge to done_o; back-to-back throughput one result per WIDTH+1 cycles.
// Backpr. : none; start_i is only accepted in IDLE or DONE and is ignored while busy_o is high (no queueing).
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    synchronous active-high reset, priority over start_i
//   start_i  request a new operation (accepted in IDLE/DONE)
//   sub_i    0: a+b+cin, 1: a-b (cin ignored); captured with start
//   a_i,b_i  operands, captured on the accepting edge
//   cin_i    carry-in for add mode, captured on the accepting edge
//   busy_o   high while bits are being processed
//   done_o   one-cycle pulse when sum_o/cout_o carry a fresh result
//   sum_o    registered result, stable between completions
//   cout_o   carry-out (add) / not-borrow (sub, 1 when a>=b)
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    // Counter needs at least one bit so WIDTH=1 still has a legal vector.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             sum_bit_d;
    logic             carry_d;
    logic [WIDTH-1:0] res_d;

    // The single full-adder cell working on the current LSBs.
    always_comb begin
        sum_bit_d = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = sum_bit_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        // Subtraction as a + ~b + 1: invert b and force carry-in.
                        a_q     <= a_i;
                        b_q     <= sub_i ? ~b_i : b_i;
                        carry_q <= sub_i ? 1'b1 : cin_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        // Only here does the result become visible.
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder_n.sv
module tb_serial_adder_n;

    typedef struct {
        int          inst;
        logic [31:0] s;
        logic        c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s [3];
    logic        sub_s   [3];
    logic        cin_s   [3];
    logic [31:0] a_s     [3];
    logic [31:0] b_s     [3];
    logic        busy_s  [3];
    logic        done_s  [3];
    logic [31:0] sum_s   [3];
    logic        cout_s  [3];

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    function automatic int wof(int g);
        return (g == 0) ? 8 : (g == 1) ? 2 : 1;
    endfunction

    // Three instances: the main 8-bit unit plus the small widths swept exhaustively.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 8 : (g == 1) ? 2 : 1;
        logic [W-1:0] sum_w;
        serial_adder_n #(.WIDTH(W)) u_dut (
            .clk_i   (clk),
            .rst_i   (rst),
            .start_i (start_s[g]),
            .sub_i   (sub_s[g]),
            .a_i     (a_s[g][W-1:0]),
            .b_i     (b_s[g][W-1:0]),
            .cin_i   (cin_s[g]),
            .busy_o  (busy_s[g]),
            .done_o  (done_s[g]),
            .sum_o   (sum_w),
            .cout_o  (cout_s[g])
        );
        assign sum_s[g] = 32'(sum_w);
    end

    // Reference: plain modular arithmetic on the operand values.
    function automatic logic [32:0] ref_calc(int w, bit sb, bit ci,
                                             longint unsigned av, longint unsigned bv);
        longint unsigned m;
        longint unsigned t;
        m  = 64'd1 << w;
        av = av % m;
        bv = bv % m;
        if (sb) begin
            t = (av + m - bv) % m;
            return {(av >= bv), t[31:0]};
        end
        t = av + bv + 64'(ci);
        return {(t >= m), 32'(t % m)};
    endfunction

    task automatic chk(input string name, input logic [32:0] got, input logic [32:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic push_exp(int g, bit sb, bit ci, logic [31:0] av, logic [31:0] bv);
        exp_t e;
        logic [32:0] r;
        r      = ref_calc(wof(g), sb, ci, 64'(av), 64'(bv));
        e.inst = g;
        e.s    = r[31:0];
        e.c    = r[32];
        exp_q.push_back(e);
    endtask

    // Wait at negedges for done; n = negedges seen since the call.
    task automatic wait_done(int g, output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy_s[g]) nbusy++;
        end while (!done_s[g] && n < 100);
        if (!done_s[g]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_done inst=%0d: no done after %0d cycles", g, n);
        end
    endtask

    // One full operation; returns at the negedge where done is visible.
    task automatic run_op(int g, bit sb, bit ci, logic [31:0] av, logic [31:0] bv);
        int n;
        int nb;
        @(negedge clk);
        a_s[g] = av; b_s[g] = bv; sub_s[g] = sb; cin_s[g] = ci; start_s[g] = 1'b1;
        push_exp(g, sb, ci, av, bv);
        @(negedge clk);
        start_s[g] = 1'b0;
        n = 1;
        nb = busy_s[g] ? 1 : 0;
        if (!done_s[g]) begin
            int m;
            int mb;
            wait_done(g, m, mb);
            n  += m;
            nb += mb;
        end
        // First negedge after the accepting edge is n=1, so edges-to-done is n-1.
        chk($sformatf("latency_w%0d", wof(g)), 33'(n - 1), 33'(wof(g)));
        chk($sformatf("busy_cycles_w%0d", wof(g)), 33'(nb), 33'(wof(g)));
    endtask

    // Monitor: every done pulse is checked against the oldest expectation.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (done_s[g]) begin
                exp_t e;
                chk($sformatf("busy_with_done_w%0d", wof(g)), 33'(busy_s[g]), 33'(0));
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_done inst=%0d: sum=%h cout=%b, no result expected",
                             g, sum_s[g], cout_s[g]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.inst != g || sum_s[g] !== e.s || cout_s[g] !== e.c) begin
                        n_bad++;
                        $display("FAIL result inst=%0d: got sum=%h cout=%b, expected inst=%0d sum=%h cout=%b",
                                 g, sum_s[g], cout_s[g], e.inst, e.s, e.c);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int nb;
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            start_s[g] = 1'b0; sub_s[g] = 1'b0; cin_s[g] = 1'b0;
            a_s[g] = '0; b_s[g] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 3; g++)
            chk($sformatf("reset_state_w%0d", wof(g)),
                {busy_s[g], done_s[g], cout_s[g], sum_s[g][29:0]}, 33'(0));

        // Directed vectors with hand-computed results.
        run_op(0, 0, 0, 32'h35, 32'h0A); chk("add_35_0a", {cout_s[0], sum_s[0]}, {1'b0, 32'h3F});
        run_op(0, 0, 1, 32'hFF, 32'h01); chk("add_ff_01_c", {cout_s[0], sum_s[0]}, {1'b1, 32'h01});
        run_op(0, 0, 1, 32'hFF, 32'h00); chk("add_ff_00_c", {cout_s[0], sum_s[0]}, {1'b1, 32'h00});
        run_op(0, 1, 0, 32'h20, 32'h10); chk("sub_20_10", {cout_s[0], sum_s[0]}, {1'b1, 32'h10});
        run_op(0, 1, 0, 32'h10, 32'h20); chk("sub_10_20", {cout_s[0], sum_s[0]}, {1'b0, 32'hF0});
        run_op(0, 1, 1, 32'h10, 32'h20); chk("sub_cin_ign", {cout_s[0], sum_s[0]}, {1'b0, 32'hF0});

        // Start in RUN is ignored (operands scrambled mid-run), then held through DONE.
        @(negedge clk);
        a_s[0] = 32'h5A; b_s[0] = 32'h33; sub_s[0] = 1'b0; cin_s[0] = 1'b1; start_s[0] = 1'b1;
        push_exp(0, 1'b0, 1'b1, 32'h5A, 32'h33);
        @(negedge clk); start_s[0] = 1'b0;
        @(negedge clk);
        @(negedge clk); start_s[0] = 1'b1; a_s[0] = 32'hFF; b_s[0] = 32'hFF; sub_s[0] = 1'b1;
        @(negedge clk);
        a_s[0] = 32'hC3; b_s[0] = 32'h3C; sub_s[0] = 1'b1; cin_s[0] = 1'b0; start_s[0] = 1'b1;
        push_exp(0, 1'b1, 1'b0, 32'hC3, 32'h3C);
        wait_done(0, n, nb);
        chk("first_of_pair", {cout_s[0], sum_s[0]}, {1'b0, 32'h8E});
        @(negedge clk); start_s[0] = 1'b0;
        chk("b2b_busy_no_gap", 33'(busy_s[0]), 33'(1));
        wait_done(0, n, nb);
        chk("done_spacing", 33'(n + 1), 33'(9));
        chk("second_of_pair", {cout_s[0], sum_s[0]}, {1'b1, 32'h87});

        // Reset in RUN cycle 4 aborts with no done pulse and clears the result.
        @(negedge clk);
        a_s[0] = 32'h77; b_s[0] = 32'h11; sub_s[0] = 1'b0; cin_s[0] = 1'b0; start_s[0] = 1'b1;
        @(negedge clk); start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_reset", {busy_s[0], done_s[0], cout_s[0], sum_s[0][29:0]}, 33'(0));
        repeat (12) @(negedge clk);
        run_op(0, 0, 0, 32'h77, 32'h11); chk("after_reset_op", {cout_s[0], sum_s[0]}, {1'b0, 32'h88});

        // Random 8-bit operations.
        for (int i = 0; i < 40; i++)
            run_op(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)));

        // Exhaustive sweeps for WIDTH=2 and WIDTH=1.
        for (int g = 1; g < 3; g++)
            for (int k = 0; k < (4 << (2 * wof(g))); k++)
                run_op(g, 1'(k >> (2 * wof(g) + 1)), 1'(k >> (2 * wof(g))),
                       32'((k >> wof(g)) & ((1 << wof(g)) - 1)), 32'(k & ((1 << wof(g)) - 1)));

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 33'(exp_q.size()), 33'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
